// File: rtl/mem_lsu.sv
// Load/store unit between a single requester and a combinational-read RAM.
// Misaligned accesses that straddle two words take an extra HI cycle; stores use same-cycle read-modify-write.
module mem_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_100MHz,
  input  logic                  arst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  ram_rena_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  output logic                  ram_wena_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t                  state;
  logic                    we;
  logic                    uns;
  logic [1:0]              size;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   lo_word;
  logic [DATA_WIDTH-1:0]   hi_word;

  logic [1:0]              offset;
  logic                    crossing;
  logic [ADDR_WIDTH-1:0]   lo_addr;
  logic [ADDR_WIDTH-1:0]   hi_addr;
  logic [3:0]              base_mask;
  logic [7:0]              store_mask;
  logic [2*DATA_WIDTH-1:0] store_wide;
  logic [3:0]              lane_mask;
  logic [DATA_WIDTH-1:0]   lane_data;
  logic [DATA_WIDTH-1:0]   load_shift;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign offset   = addr[1:0];
  assign crossing = (size[1] && offset != 2'b00) || (size == 2'b01 && offset == 2'b11);
  assign lo_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign hi_addr  = lo_addr + ADDR_WIDTH'(4);

  always_comb begin
    case (size)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // Byte lanes and data are laid out across a 64-bit LO/HI pair, low half to LO.
  assign store_mask = {4'b0000, base_mask} << offset;
  assign store_wide = {{DATA_WIDTH{1'b0}}, wdata} << {offset, 3'b000};
  assign load_shift = DATA_WIDTH'({hi_word, lo_word} >> {offset, 3'b000});

  always_comb begin
    case (size)
      2'b00:   load_ext = uns ? {{(DATA_WIDTH-8){1'b0}}, load_shift[7:0]}
                              : {{(DATA_WIDTH-8){load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_ext = uns ? {{(DATA_WIDTH-16){1'b0}}, load_shift[15:0]}
                              : {{(DATA_WIDTH-16){load_shift[15]}}, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  assign resp_valid_o = (state == RESP);
  assign resp_rdata_o = (state == RESP && !we) ? load_ext : '0;

  always_comb begin
    ram_rena_o  = 1'b0;
    ram_raddr_o = '0;
    ram_wena_o  = 1'b0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    lane_mask   = 4'b0000;
    lane_data   = '0;
    case (state)
      LO: begin
        ram_rena_o  = 1'b1;
        ram_raddr_o = lo_addr;
        lane_mask   = store_mask[3:0];
        lane_data   = store_wide[DATA_WIDTH-1:0];
      end
      HI: begin
        ram_rena_o  = 1'b1;
        ram_raddr_o = hi_addr;
        lane_mask   = store_mask[7:4];
        lane_data   = store_wide[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
    // Stores merge their lanes into the word being read in the same cycle.
    if (we && ram_rena_o) begin
      ram_wena_o  = 1'b1;
      ram_waddr_o = ram_raddr_o;
      for (int i = 0; i < 4; i++)
        ram_wdata_o[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : ram_rdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      req_ready_o <= 1'b0;
      we          <= 1'b0;
      uns         <= 1'b0;
      size        <= 2'b00;
      addr        <= '0;
      wdata       <= '0;
      lo_word     <= '0;
      hi_word     <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            we          <= req_we_i;
            uns         <= req_unsigned_i;
            size        <= req_size_i;
            addr        <= req_addr_i;
            wdata       <= req_wdata_i;
            req_ready_o <= 1'b0;
            state       <= LO;
          end
        end
        LO: begin
          lo_word <= ram_rdata_i;
          hi_word <= '0;
          state   <= crossing ? HI : RESP;
        end
        HI: begin
          hi_word <= ram_rdata_i;
          state   <= RESP;
        end
        RESP: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a table of load/store vectors against a small word RAM,
// plus hand-written reset-abort and back-to-back throughput sequences.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ram_rena;
  logic [31:0] ram_raddr;
  logic        ram_wena;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_100MHz    (clk),
    .arst_n        (arst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_unsigned_i(req_unsigned),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .ram_rena_o    (ram_rena),
    .ram_raddr_o   (ram_raddr),
    .ram_wena_o    (ram_wena),
    .ram_waddr_o   (ram_waddr),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata)
  );

  // 16-word RAM indexed by address bits [5:2]; 0xFFFFFFFC lands on word 15.
  logic [31:0] mem [16] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic        log_clear = 1'b0;
  logic [31:0] pre_addr = 32'h0;
  logic [31:0] pre_data = 32'h0;
  int          wr_count = 0;
  logic [31:0] wa0 = 32'h0, wd0 = 32'h0, wa1 = 32'h0, wd1 = 32'h0;

  assign ram_rdata = mem[ram_raddr[5:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr[5:2]] <= pre_data;
    else if (ram_wena) mem[ram_waddr[5:2]] <= ram_wdata;
    if (log_clear) wr_count <= 0;
    else if (ram_wena) begin
      if (wr_count == 0) begin
        wa0 <= ram_waddr;
        wd0 <= ram_wdata;
      end
      wa1 <= ram_waddr;
      wd1 <= ram_wdata;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic        pre_en;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wa0;
    logic [31:0] exp_wd0;
    logic [31:0] exp_wa1;
    logic [31:0] exp_wd1;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic preload(input logic en, input logic [31:0] a, input logic [31:0] d);
    pre_en    = en;
    pre_addr  = a;
    pre_data  = d;
    log_clear = 1'b1;
    @(posedge clk); #1;
    pre_en    = 1'b0;
    log_clear = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int   w;
    int   lat;
    v = vecs[idx];
    preload(v.pre_en, v.pre_addr, v.pre_data);
    w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    checkOutput($sformatf("v%0d_lo_raddr", idx), ram_raddr, v.addr & 32'hFFFF_FFFC);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    checkOutput($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_pulse_end", idx), {31'b0, resp_valid}, 32'd0);
    checkOutput($sformatf("v%0d_rdata_idle", idx), resp_rdata, 32'd0);
    checkOutput($sformatf("v%0d_writes", idx), wr_count, v.exp_wr);
    if (v.exp_wr > 0) begin
      checkOutput($sformatf("v%0d_waddr0", idx), wa0, v.exp_wa0);
      checkOutput($sformatf("v%0d_wdata0", idx), wd0, v.exp_wd0);
      checkOutput($sformatf("v%0d_waddr1", idx), wa1, v.exp_wa1);
      checkOutput($sformatf("v%0d_wdata1", idx), wd1, v.exp_wd1);
    end
  endtask

  initial begin
    int         resp_seen;
    logic [3:0] resp_pat;
    logic [3:0] ready_pat;

    // pre_en pre_addr pre_data | we size uns addr wdata | exp_rdata lat writes wa0 wd0 wa1 wd1
    vecs[0]  = '{1'b1, 32'h10, 32'h8899AABB, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008899, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000BB, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAABB, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 32'h14, 32'h88776655, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'h00000055, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 32'h10, 32'h44332211, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h55443322, 3, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h00005544, 3, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h00003322, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 32'h77665544, 3, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0, 32'h21, 32'h1234565A, 32'h0, 2, 1, 32'h20, 32'hFFFF5AFF, 32'h20, 32'hFFFF5AFF};
    vecs[11] = '{1'b0, 32'h0,  32'h0,        1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h0, 2, 1, 32'h20, 32'hBEEF5AFF, 32'h20, 32'hBEEF5AFF};
    vecs[12] = '{1'b1, 32'h0,  32'h22222222, 1'b0, 2'b00, 1'b1, 32'h0,  32'h0, 32'h00000022, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 32'hFFFFFFFC, 32'h11111111, 1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hDDCCBBAA, 32'h0, 3, 2,
                 32'hFFFFFFFC, 32'hBBAA1111, 32'h00000000, 32'h2222DDCC};
    vecs[14] = '{1'b0, 32'h0,  32'h0,        1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 32'hDDCCBBAA, 3, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[15] = '{1'b1, 32'h10, 32'h44332211, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000A1B2, 32'h0, 3, 2,
                 32'h10, 32'hB2332211, 32'h14, 32'h887766A1};

    arst_n       = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    #3;
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_rena", {31'b0, ram_rena}, 32'd0);
    checkOutput("rst_wena", {31'b0, ram_wena}, 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    #9;
    arst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rel_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) applyStimulus(i);

    // Reset pulsed during LO of a crossing store: nothing may commit afterwards.
    preload(1'b0, 32'h0, 32'h0);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("abort_lo_wena", {31'b0, ram_wena}, 32'd1);
    arst_n = 1'b0;
    #1;
    checkOutput("abort_wena", {31'b0, ram_wena}, 32'd0);
    checkOutput("abort_rena", {31'b0, ram_rena}, 32'd0);
    checkOutput("abort_raddr", ram_raddr, 32'd0);
    checkOutput("abort_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #2;
    arst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready_rel", {31'b0, req_ready}, 32'd1);
    resp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) resp_seen++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_resp", resp_seen, 0);
    checkOutput("abort_no_writes", wr_count, 0);
    checkOutput("abort_mem_lo", mem[4], 32'hB2332211);
    checkOutput("abort_mem_hi", mem[5], 32'h887766A1);

    // Held request: back-to-back non-crossing loads every 3 cycles.
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b1;
    req_addr = 32'h14; req_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      resp_pat[3-k]  = resp_valid;
      ready_pat[3-k] = req_ready;
      if (k == 3) checkOutput("b2b_rdata", resp_rdata, 32'h000000A1);
    end
    req_valid = 1'b0;
    checkOutput("b2b_resp_pattern", {28'b0, resp_pat}, 32'h9);
    checkOutput("b2b_ready_pattern", {28'b0, ready_pat}, 32'h4);
    @(posedge clk); #1;
    checkOutput("b2b_idle", {31'b0, resp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width; only 32 is supported.
REQ-003 SHALL have port clk_100MHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid_i, input, 1 bit: access request present.
REQ-006 SHALL have port req_ready_o, output, 1 bit: LSU can accept a request.
REQ-007 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 or 11 = word.
REQ-009 SHALL have port req_unsigned_i, input, 1 bit: zero-extend loads when 1.
REQ-010 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata_i, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid_o, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata_o, output, 32 bits: extended load result; 0 for stores.
REQ-014 SHALL have ports ram_rena_o (output, 1 bit) and ram_raddr_o (output, 32 bits): RAM read enable and byte address, word-aligned ([1:0]=0).
REQ-015 SHALL have ports ram_wena_o (output, 1 bit), ram_waddr_o (output, 32 bits) and ram_wdata_o (output, 32 bits): RAM write controls.
REQ-016 SHALL have port ram_rdata_i, input, 32 bits: RAM word, combinational from ram_raddr_o.

Function
REQ-017 SHALL implement FSM states IDLE, LO, HI, RESP.
REQ-018 SHALL drive req_ready_o = 1 only in IDLE.
REQ-019 SHALL accept a request on the edge where req_valid_i and req_ready_o are both 1, register all req_* fields, and go to LO.
REQ-020 SHALL flag a request as crossing when it is a word with addr[1:0] != 0, or a half with addr[1:0] = 3.
REQ-021 SHALL in LO drive ram_raddr_o = {addr[31:2],2'b00} with ram_rena_o = 1.
REQ-022 SHALL in HI drive ram_raddr_o = LO word address + 4; 32-bit wrap, so 0xFFFFFFFC+4 = 0x00000000.
REQ-023 SHALL go LO->HI when crossing, otherwise LO->RESP; HI->RESP always; RESP->IDLE always.
REQ-024 SHALL capture ram_rdata_i into lo_word in LO and hi_word in HI; hi_word = 0 when not crossing.
REQ-025 SHALL for stores in LO/HI perform read-modify-write in the same cycle: ram_wena_o = 1, ram_waddr_o = ram_raddr_o, ram_wdata_o = ram_rdata_i with only addressed byte lanes replaced.
REQ-026 SHALL map lanes little-endian: the store data shifted left by 8*addr[1:0] as a 64-bit value, low 32 bits to the LO word, high 32 bits to the HI word.
REQ-027 SHALL set ram_wena_o = 0 in LO/HI for loads, and ram_rena_o = ram_wena_o = 0 in IDLE and RESP, with all RAM addresses and data = 0.
REQ-028 SHALL in RESP assert resp_valid_o = 1 for exactly one cycle.
REQ-029 SHALL for loads form resp_rdata_o from {hi_word,lo_word} >> 8*addr[1:0], truncated to size, then sign- or zero-extended per req_unsigned_i.
REQ-030 SHALL keep resp_rdata_o = 0 when resp_valid_o = 0.
REQ-031 SHALL have latency, from the accept edge to resp_valid_o high, of 2 cycles non-crossing and 3 cycles crossing.
REQ-032 SHALL achieve maximum throughput of one non-crossing access per 3 cycles.
REQ-033 SHALL ignore req_valid_i outside IDLE; requests are neither queued nor dropped silently, the requester holds them.

Reset
REQ-034 SHALL on arst_n = 0 immediately force IDLE, req_ready_o = 0, resp_valid_o = 0, resp_rdata_o = 0, ram_rena_o = ram_wena_o = 0, all RAM addresses/data = 0, and clear captured fields.
REQ-035 SHALL abandon an in-flight access when reset arrives mid-operation; no HI write is issued after reset, and the pending response is discarded.
REQ-036 SHALL after reset release assert req_ready_o = 1 from the first rising edge onward.

Verification
REQ-037 SHALL cover: RAM word 0x10 = 0x8899AABB; load byte signed at addr 0x13 -> resp_rdata_o = 0xFFFFFF88 at accept+2 cycles.
REQ-038 SHALL cover: same word, load half unsigned at addr 0x12 -> resp_rdata_o = 0x00008899.
REQ-039 SHALL cover: words 0x10 = 0x44332211, 0x14 = 0x88776655; load word at addr 0x11 -> LO then HI reads, resp_rdata_o = 0x55443322 at accept+3 cycles.
REQ-040 SHALL cover: word 0x20 = 0xFFFFFFFF; store byte 0x5A at addr 0x21 -> single write, ram_wdata_o = 0xFFFF5AFF, then resp_valid_o pulse with resp_rdata_o = 0.
REQ-041 SHALL cover: store word 0xDDCCBBAA at addr 0xFFFFFFFE -> writes land at word 0xFFFFFFFC (lanes 3:2 = 0xBBAA) and word 0x00000000 (lanes 1:0 = 0xDDCC).
REQ-042 SHALL cover: arst_n pulsed low during LO of a crossing store -> no HI write, no resp_valid_o, req_ready_o = 1 one cycle after release.
